// File: rtl/noc_input_unit_if.sv
// Link-side and allocator-side signals of one router input port.
// The input unit uses the master modport; the link/allocator environment uses the slave modport.
interface noc_input_unit_if #(
   parameter int unsigned FLIT_W = 19
);
   logic [FLIT_W-1:0] in_flit;
   logic              credit_out;
   logic [FLIT_W-1:0] out_flit;
   logic [2:0]        out_port;
   logic              out_req;
   logic              out_grant;

   modport master (
      input  in_flit,
      input  out_grant,
      output credit_out,
      output out_flit,
      output out_port,
      output out_req
   );

   modport slave (
      output in_flit,
      output out_grant,
      input  credit_out,
      input  out_flit,
      input  out_port,
      input  out_req
   );
endinterface

// File: rtl/noc_input_unit.sv
// Mesh router input unit: flit FIFO, XY route computation on head flits,
// wormhole route lock until the tail leaves, one upstream credit per dequeued flit.
module noc_input_unit #(
   parameter int unsigned COORD_W = 8,
   parameter int unsigned DEPTH   = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [COORD_W-1:0]       router_x,
   input  logic [COORD_W-1:0]       router_y,
   noc_input_unit_if.master         link,
   output logic [$clog2(DEPTH):0]   occupancy,
   output logic                     overflow_err,
   output logic                     proto_err
);
   localparam int unsigned FLIT_W = 3 + 2 * COORD_W;
   localparam int unsigned PTR_W  = $clog2(DEPTH);
   localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W + 1)'(DEPTH);

   typedef enum logic [1:0] {IDLE, ROUTING, ACTIVE} state_t;
   typedef enum logic [1:0] {F_HEAD, F_TAIL, F_BODY, F_NONE} flit_type_t;
   typedef enum logic [2:0] {P_LOCAL, P_NORTH, P_SOUTH, P_EAST, P_WEST, P_NONE} port_t;

   logic [FLIT_W-1:0]  mem [DEPTH];
   logic [PTR_W-1:0]   rd_ptr, wr_ptr;
   logic [PTR_W:0]     count;
   logic [FLIT_W-1:0]  front;
   flit_type_t         front_type;
   logic [COORD_W-1:0] head_x, head_y;
   state_t             state, state_next;
   port_t              route_q, route_calc;
   logic               full, empty, push, pop, discard, credit_q;

   assign full       = (count == DEPTH_CNT);
   assign empty      = (count == '0);
   // Fullness is judged before any same-cycle pop, so a push while full is always dropped.
   assign push       = link.in_flit[FLIT_W-1] && !full;
   assign front      = mem[rd_ptr];
   assign front_type = flit_type_t'(front[FLIT_W-2 -: 2]);
   assign head_x     = front[2*COORD_W-1 -: COORD_W];
   assign head_y     = front[COORD_W-1:0];

   assign link.out_flit   = front;
   assign link.credit_out = credit_q;
   assign occupancy       = count;

   always_comb begin
      route_calc = P_LOCAL;
      if (head_x > router_x)      route_calc = P_EAST;
      else if (head_x < router_x) route_calc = P_WEST;
      else if (head_y > router_y) route_calc = P_NORTH;
      else if (head_y < router_y) route_calc = P_SOUTH;
   end

   always_comb begin
      state_next    = state;
      pop           = 1'b0;
      discard       = 1'b0;
      link.out_req  = 1'b0;
      link.out_port = P_NONE;
      case (state)
         IDLE: begin
            if (!empty) begin
               if (front_type == F_HEAD) begin
                  state_next = ROUTING;
               end else begin
                  pop     = 1'b1;
                  discard = 1'b1;
               end
            end
         end
         ROUTING: state_next = ACTIVE;
         ACTIVE: begin
            link.out_req  = !empty;
            link.out_port = route_q;
            if (!empty && link.out_grant) begin
               pop = 1'b1;
               if (front_type == F_TAIL) state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         route_q      <= P_NONE;
         rd_ptr       <= '0;
         wr_ptr       <= '0;
         count        <= '0;
         credit_q     <= 1'b0;
         overflow_err <= 1'b0;
         proto_err    <= 1'b0;
      end else begin
         state    <= state_next;
         credit_q <= pop;
         if (state == ROUTING) route_q <= route_calc;
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         if (push && !pop)      count <= count + 1'b1;
         else if (!push && pop) count <= count - 1'b1;
         if (link.in_flit[FLIT_W-1] && full) overflow_err <= 1'b1;
         if (discard) proto_err <= 1'b1;
      end
   end

   // Storage is deliberately not reset; out_flit is meaningless while empty.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= link.in_flit;
   end
endmodule

// File: tb/tb_noc_input_unit.sv
// Self-checking bench for noc_input_unit: queue-based reference model checked every cycle,
// a route vector table, and directed multi-cycle sequences.
module tb_noc_input_unit;
   localparam int unsigned COORD_W = 8;
   localparam int unsigned DEPTH   = 4;
   localparam int unsigned FLIT_W  = 3 + 2 * COORD_W;
   localparam logic [1:0] T_HEAD = 2'd0, T_TAIL = 2'd1, T_BODY = 2'd2;
   localparam int PH_IDLE = 0, PH_ROUTE = 1, PH_ACTIVE = 2;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic [7:0] router_x = 8'd2;
   logic [7:0] router_y = 8'd2;
   logic [2:0] occupancy;
   logic       overflow_err, proto_err;

   noc_input_unit_if #(.FLIT_W(FLIT_W)) bus ();

   noc_input_unit #(.COORD_W(COORD_W), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n), .router_x(router_x), .router_y(router_y),
      .link(bus), .occupancy(occupancy),
      .overflow_err(overflow_err), .proto_err(proto_err)
   );

   always #5 clk = ~clk;

   int n_cmp = 0, n_bad = 0;

   // Reference model: stored flits as a queue plus packet phase.
   logic [FLIT_W-1:0] mq [$];
   int                m_phase;
   logic [2:0]        m_route;
   logic              m_credit, m_ovf, m_perr;
   int                m_fwd;

   int         cyc = 0;
   int         credits_seen, up_credits, max_occ;
   int         pop_cnt, first_pop, last_pop, first_req;
   logic       seen_req;
   logic [2:0] seen_port;
   logic [FLIT_W-1:0] pending [$];

   typedef struct {
      logic [7:0] x;
      logic [7:0] y;
      logic [2:0] port;
   } route_vec_t;
   route_vec_t rt [5];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [FLIT_W-1:0] mk(input logic [1:0] t, input logic [15:0] p);
      return {1'b1, t, p};
   endfunction

   function automatic logic [2:0] xy_route(input logic [FLIT_W-1:0] f);
      int unsigned x, y;
      x = f[15:8];
      y = f[7:0];
      if (x > router_x) return 3'd3;
      if (x < router_x) return 3'd4;
      if (y > router_y) return 3'd1;
      if (y < router_y) return 3'd2;
      return 3'd0;
   endfunction

   task automatic model_reset();
      mq.delete();
      m_phase  = PH_IDLE;
      m_route  = 3'd5;
      m_credit = 1'b0;
      m_ovf    = 1'b0;
      m_perr   = 1'b0;
   endtask

   task automatic model_step(input logic [FLIT_W-1:0] f, input logic g);
      logic              was_full, popped;
      logic [FLIT_W-1:0] h;
      was_full = (mq.size() == DEPTH);
      popped   = 1'b0;
      if (m_phase == PH_IDLE) begin
         if (mq.size() > 0) begin
            if (mq[0][17:16] == T_HEAD) m_phase = PH_ROUTE;
            else begin
               h      = mq.pop_front();
               m_perr = 1'b1;
               popped = 1'b1;
            end
         end
      end else if (m_phase == PH_ROUTE) begin
         m_route = xy_route(mq[0]);
         m_phase = PH_ACTIVE;
      end else if (mq.size() > 0 && g) begin
         h      = mq.pop_front();
         popped = 1'b1;
         m_fwd++;
         if (h[17:16] == T_TAIL) m_phase = PH_IDLE;
      end
      if (f[18]) begin
         if (was_full) m_ovf = 1'b1;
         else mq.push_back(f);
      end
      m_credit = popped;
   endtask

   task automatic check_outputs();
      check("occupancy", 32'(occupancy), 32'(mq.size()));
      check("out_req", 32'(bus.out_req), 32'(m_phase == PH_ACTIVE && mq.size() > 0));
      check("out_port", 32'(bus.out_port), 32'((m_phase == PH_ACTIVE) ? m_route : 3'd5));
      check("credit_out", 32'(bus.credit_out), 32'(m_credit));
      check("overflow_err", 32'(overflow_err), 32'(m_ovf));
      check("proto_err", 32'(proto_err), 32'(m_perr));
      if (mq.size() > 0) check("out_flit", 32'(bus.out_flit), 32'(mq[0]));
   endtask

   // One clock: drive at posedge+1, check at negedge, advance model at posedge.
   task automatic cycle(input logic [FLIT_W-1:0] f, input logic g);
      bus.in_flit   = f;
      bus.out_grant = g;
      #4;
      check_outputs();
      if (bus.credit_out) begin
         credits_seen++;
         up_credits++;
      end
      if (bus.out_req && !seen_req) begin
         seen_req  = 1'b1;
         seen_port = bus.out_port;
         first_req = cyc;
      end
      if (bus.out_req && g) begin
         if (pop_cnt == 0) first_pop = cyc;
         last_pop = cyc;
         pop_cnt++;
      end
      if (int'(occupancy) > max_occ) max_occ = int'(occupancy);
      @(posedge clk);
      model_step(f, g);
      cyc++;
      #1;
   endtask

   task automatic do_reset();
      rst_n         = 1'b0;
      bus.in_flit   = '0;
      bus.out_grant = 1'b0;
      model_reset();
      #1;
      check("rst_occupancy", 32'(occupancy), 32'd0);
      check("rst_out_req", 32'(bus.out_req), 32'd0);
      check("rst_out_port", 32'(bus.out_port), 32'd5);
      check("rst_credit_out", 32'(bus.credit_out), 32'd0);
      check("rst_overflow_err", 32'(overflow_err), 32'd0);
      check("rst_proto_err", 32'(proto_err), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic clear_stats();
      credits_seen = 0;
      pop_cnt      = 0;
      first_pop    = -1;
      last_pop     = -1;
      first_req    = -1;
      seen_req     = 1'b0;
      seen_port    = 3'd7;
      max_occ      = 0;
      m_fwd        = 0;
   endtask

   task automatic send_packet_route(input logic [7:0] x, input logic [7:0] y);
      seen_req  = 1'b0;
      seen_port = 3'd7;
      cycle(mk(T_HEAD, {x, y}), 1'b1);
      cycle(mk(T_TAIL, 16'($urandom)), 1'b1);
      repeat (6) cycle('0, 1'b1);
   endtask

   initial begin
      int head_cyc, sent;
      logic g;
      logic [FLIT_W-1:0] f;

      rt[0] = '{x: 8'd0, y: 8'd2, port: 3'd4};
      rt[1] = '{x: 8'd2, y: 8'd7, port: 3'd1};
      rt[2] = '{x: 8'd2, y: 8'd0, port: 3'd2};
      rt[3] = '{x: 8'd2, y: 8'd2, port: 3'd0};
      rt[4] = '{x: 8'd9, y: 8'd9, port: 3'd3};

      bus.in_flit   = '0;
      bus.out_grant = 1'b0;
      model_reset();
      clear_stats();
      @(posedge clk);
      #1;
      do_reset();

      // Main packet, grant held high.
      clear_stats();
      head_cyc = cyc;
      cycle(mk(T_HEAD, {8'd5, 8'd1}), 1'b1);
      cycle(mk(T_BODY, 16'h1111), 1'b1);
      cycle(mk(T_BODY, 16'h2222), 1'b1);
      cycle(mk(T_TAIL, 16'h3333), 1'b1);
      repeat (6) cycle('0, 1'b1);
      check("main_req_latency", 32'(first_req - head_cyc), 32'd3);
      check("main_port", 32'(seen_port), 32'd3);
      check("main_pops", 32'(pop_cnt), 32'd4);
      check("main_pop_span", 32'(last_pop - first_pop), 32'd3);
      check("main_credits", 32'(credits_seen), 32'd4);
      check("main_end_port", 32'(bus.out_port), 32'd5);

      // Route table at (2,2).
      foreach (rt[i]) begin
         send_packet_route(rt[i].x, rt[i].y);
         check($sformatf("route_%0d", i), 32'(seen_port), 32'(rt[i].port));
      end

      // Backpressure and overflow.
      clear_stats();
      cycle(mk(T_HEAD, {8'd9, 8'd2}), 1'b0);
      cycle(mk(T_BODY, 16'hAAAA), 1'b0);
      cycle(mk(T_BODY, 16'hBBBB), 1'b0);
      cycle(mk(T_TAIL, 16'hCCCC), 1'b0);
      repeat (3) cycle('0, 1'b0);
      check("bp_occ_full", 32'(occupancy), 32'd4);
      cycle(mk(T_BODY, 16'hDDDD), 1'b0);
      cycle('0, 1'b0);
      check("bp_overflow", 32'(overflow_err), 32'd1);
      check("bp_occ_kept", 32'(occupancy), 32'd4);
      check("bp_no_credit", 32'(credits_seen), 32'd0);
      repeat (8) cycle('0, 1'b1);
      check("bp_credits", 32'(credits_seen), 32'd4);
      check("bp_pops", 32'(pop_cnt), 32'd4);
      do_reset();

      // Protocol error: stray BODY while idle.
      clear_stats();
      cycle(mk(T_BODY, 16'h5A5A), 1'b0);
      repeat (3) cycle('0, 1'b0);
      check("pe_flag", 32'(proto_err), 32'd1);
      check("pe_credit", 32'(credits_seen), 32'd1);
      check("pe_occ", 32'(occupancy), 32'd0);
      check("pe_idle_req", 32'(bus.out_req), 32'd0);
      send_packet_route(8'd2, 8'd7);
      check("pe_next_route", 32'(seen_port), 32'd1);

      // Reset while a packet is locked.
      clear_stats();
      cycle(mk(T_HEAD, {8'd0, 8'd0}), 1'b0);
      cycle(mk(T_BODY, 16'h7777), 1'b0);
      repeat (3) cycle('0, 1'b0);
      check("mid_active_req", 32'(bus.out_req), 32'd1);
      check("mid_active_port", 32'(bus.out_port), 32'd4);
      do_reset();
      clear_stats();
      send_packet_route(8'd9, 8'd9);
      check("mid_after_route", 32'(seen_port), 32'd3);
      check("mid_after_credits", 32'(credits_seen), 32'd2);

      // Wrap-around: credit-paced sender, grant toggling.
      clear_stats();
      up_credits = DEPTH;
      pending.delete();
      for (int p = 0; p < 10; p++) begin
         pending.push_back(mk(T_HEAD, {8'($urandom_range(0, 4)), 8'($urandom_range(0, 4))}));
         pending.push_back(mk(T_TAIL, 16'($urandom)));
      end
      sent = 0;
      g = 1'b1;
      for (int c = 0; c < 400; c++) begin
         if (pending.size() == 0 && mq.size() == 0 && m_phase == PH_IDLE && c > 4) break;
         f = '0;
         if (pending.size() > 0 && up_credits > 0) begin
            f = pending.pop_front();
            up_credits--;
            sent++;
         end
         cycle(f, g);
         g = !g;
      end
      repeat (2) cycle('0, 1'b0);
      check("wrap_sent", 32'(sent), 32'd20);
      check("wrap_delivered", 32'(m_fwd), 32'd20);
      check("wrap_pops", 32'(pop_cnt), 32'd20);
      check("wrap_credits", 32'(credits_seen), 32'd20);
      check("wrap_max_occ_ok", 32'(max_occ <= 4), 32'd1);
      check("wrap_no_overflow", 32'(overflow_err), 32'd0);
      check("wrap_no_proto", 32'(proto_err), 32'd0);

      // Randomized traffic with occasional stray flits, checked against the model.
      up_credits = DEPTH;
      pending.delete();
      for (int c = 0; c < 600; c++) begin
         if (pending.size() == 0) begin
            if ($urandom_range(0, 9) == 0) begin
               pending.push_back(mk(2'($urandom_range(1, 3)), 16'($urandom)));
            end else begin
               pending.push_back(mk(T_HEAD, {8'($urandom_range(0, 4)), 8'($urandom_range(0, 4))}));
               repeat ($urandom_range(0, 3)) pending.push_back(mk(T_BODY, 16'($urandom)));
               pending.push_back(mk(T_TAIL, 16'($urandom)));
            end
         end
         f = '0;
         if (up_credits > 0 && $urandom_range(0, 3) != 0) begin
            f = pending.pop_front();
            up_credits--;
         end
         cycle(f, 1'($urandom_range(0, 1)));
      end
      repeat (20) cycle('0, 1'b1);
      check("rand_no_overflow", 32'(overflow_err), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/noc_input_unit.md
# noc_input_unit

Parametrised input port unit for the mesh router. It buffers incoming flits in a DEPTH-deep FIFO, computes an XY route from each head flit against the router's own coordinates, and holds that route (wormhole lock) until the tail flit leaves. It returns one credit upstream per dequeued flit and sits between a link receiver and the switch allocator/crossbar, one instance per port.

## Interface
Parameters:
- COORD_W, 8, bits per coordinate (xaddr, yaddr).
- DEPTH, 4, FIFO depth in flits; power of two, ≥2.
- FLIT_W (derived), 3+2*COORD_W (19 by default); layout {valid, type[1:0], payload}. Head payload is {xaddr, yaddr}, xaddr in the upper half.

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- router_x  in  COORD_W  this router's X coordinate; quasi-static.
- router_y  in  COORD_W  this router's Y coordinate; quasi-static.
- in_flit  in  FLIT_W  incoming flit; written when bit FLIT_W-1 (valid) = 1.
- credit_out  out  1  one-cycle pulse per freed buffer slot.
- out_flit  out  FLIT_W  FIFO front flit.
- out_port  out  3  locked route: LOCAL=0, NORTH=1, SOUTH=2, EAST=3, WEST=4, NONE=5.
- out_req  out  1  request to the switch allocator.
- out_grant  in  1  grant; a flit is popped when out_req && out_grant.
- occupancy  out  $clog2(DEPTH)+1  flits currently stored.
- overflow_err  out  1  sticky; a valid flit arrived while full.
- proto_err  out  1  sticky; a non-HEAD flit was at the front while IDLE.

## Operation
- Flit types: HEAD=0, TAIL=1, BODY=2, NONE=3. A packet is HEAD, zero or more BODY, then TAIL.
- Write: a valid in_flit is pushed if the FIFO is not full. Fullness is evaluated before any same-cycle pop, so a push while full is dropped even if a pop occurs in that cycle. A dropped push sets overflow_err and returns no credit.
- The FIFO uses binary read/write pointers of $clog2(DEPTH) bits that wrap modulo DEPTH. Occupancy changes by +1 on push, -1 on pop, 0 on both.
- XY route (unsigned compare):
  - xaddr>router_x → EAST; xaddr<router_x → WEST.
  - Otherwise yaddr>router_y → NORTH; yaddr<router_y → SOUTH.
  - Otherwise LOCAL.
- State machine:
  - IDLE: out_req=0, out_port=NONE.
    - FIFO non-empty, front type HEAD → ROUTING.
    - Front is BODY, TAIL or NONE → pop and discard it, set proto_err, return a credit; stay in IDLE.
  - ROUTING: register the XY route of the front head flit into out_port → ACTIVE. out_req=0.
  - ACTIVE: out_req = FIFO non-empty; out_port holds the locked route. On pop, if the popped flit is TAIL → IDLE (out_port=NONE next cycle); otherwise stay.
  - A HEAD arriving at the front while ACTIVE is forwarded as data (no re-route). Upstream must not interleave packets.
- Credits: credit_out is registered and pulses in the cycle after every pop, whether forwarded or discarded. Upstream initialises its counter to DEPTH.
- Error flags clear only on reset.

## Timing
- Reset (async assert, sync-safe deassert by the top level):
  - state=IDLE, pointers=0, occupancy=0.
  - out_req=0, out_port=NONE(5), credit_out=0, overflow_err=0, proto_err=0.
  - out_flit = stale storage; don't-care while occupancy=0.
- Reset mid-packet discards all stored flits and the lock. No credits are issued for the discarded flits.
- Head latency: head written at edge E0 → IDLE sees it after E0 → ROUTING after E1 → out_req=1 after E2. This gives 2 cycles of idle latency.
- Streaming: in ACTIVE with continuous grant and a non-empty FIFO, one flit per cycle.
- Tail→next head: tail popped at edge T → IDLE after T → ROUTING after T+1 → out_req after T+2.
- out_req, out_port and out_flit are stable within a cycle. out_flit is combinational from storage and the read pointer. Grant is sampled at the rising edge.
- Simultaneous push and pop when neither full nor empty: both occur, occupancy unchanged.
- Push into an empty FIFO: the flit is visible at out_flit in the next cycle, not the same cycle.

## Test plan
- Router (2,2), DEPTH=4, packet HEAD(x=5,y=1)/BODY/BODY/TAIL with grant held 1:
  - out_port=3 and out_req=1 from 2 cycles after the head write.
  - Four flits leave on consecutive cycles.
  - Four credit_out pulses, each one cycle after its pop.
  - Then out_port=5, out_req=0.
- Route table at (2,2):
  - heads (0,2)→4, (2,7)→1, (2,0)→2, (2,2)→0, (9,9)→3.
  - Each packet is a HEAD+TAIL pair.
- Backpressure: grant=0 with 4 flits queued → occupancy=4, no credits.
  - A 5th valid flit → overflow_err=1, occupancy stays 4.
  - Grant=1 → 4 pops, 4 credits.
- Protocol error: BODY written while IDLE → proto_err=1, flit discarded, one credit pulse, state stays IDLE.
  - A following HEAD routes normally.
- Reset mid-packet: assert rst_n=0 after HEAD+BODY are queued and while ACTIVE.
  - All outputs immediately return to reset values, occupancy=0.
  - After release, a new packet routes correctly.
- Wrap-around: 10 back-to-back 2-flit packets with grant toggling 1/0 each cycle.
  - All flits are delivered in order, 20 credits total.
  - Occupancy never exceeds 4, no error flags set.
